// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage_pkg
//  Purpose  : Shared ALU op encodings, register-zero address and default
//             widths for the ALU issue stage and its forwarding muxes.
//  Revision : 1.0  initial release
// ============================================================================
package alu_issue_stage_pkg;

    // Default data-path and field widths
    localparam int c_opcode_width    = 4;
    localparam int c_sa_width        = 5;
    localparam int c_operand_width   = 32;
    localparam int c_reg_addr_width  = 5;
    localparam int c_stall_cnt_width = 16;

    // Architectural zero register: never a forwarding target
    localparam logic [c_reg_addr_width-1:0] c_reg_zero = '0;

    // ALU operation encodings shared with the ALU
    localparam logic [c_opcode_width-1:0] c_alu_add  = 4'b0000;
    localparam logic [c_opcode_width-1:0] c_alu_sub  = 4'b0001;
    localparam logic [c_opcode_width-1:0] c_alu_and  = 4'b0010;
    localparam logic [c_opcode_width-1:0] c_alu_or   = 4'b0011;
    localparam logic [c_opcode_width-1:0] c_alu_xor  = 4'b0100;
    localparam logic [c_opcode_width-1:0] c_alu_slt  = 4'b0101;
    localparam logic [c_opcode_width-1:0] c_alu_sltu = 4'b0110;
    localparam logic [c_opcode_width-1:0] c_alu_lui  = 4'b0111;
    localparam logic [c_opcode_width-1:0] c_alu_sll  = 4'b1000;
    localparam logic [c_opcode_width-1:0] c_alu_srl  = 4'b1001;
    localparam logic [c_opcode_width-1:0] c_alu_sra  = 4'b1010;

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_mux
//  Purpose  : Two-source RAW forwarding priority mux for one source operand.
//             EX result beats the writeback bus, which beats the register
//             file. Register zero never forwards.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_mux
    import alu_issue_stage_pkg::*;
#(
    parameter int OPERAND_WIDTH  = c_operand_width,
    parameter int REG_ADDR_WIDTH = c_reg_addr_width
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [OPERAND_WIDTH-1:0]  i_rf_data,
    input  logic                      i_ex_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic [OPERAND_WIDTH-1:0]  i_ex_data,
    input  logic                      i_wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
    input  logic [OPERAND_WIDTH-1:0]  i_wb_data,
    output logic [OPERAND_WIDTH-1:0]  o_data
);

    localparam logic [REG_ADDR_WIDTH-1:0] c_zero = REG_ADDR_WIDTH'(c_reg_zero);

    logic w_rs_nz;
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_rs_nz  = (i_rs != c_zero);
    assign w_ex_hit = i_ex_en && (i_ex_rd == i_rs) && w_rs_nz;
    assign w_wb_hit = i_wb_we && (i_wb_rd == i_rs) && w_rs_nz;

    // Priority select: in-flight EX result is younger than the WB value
    always_comb begin
        o_data = i_rf_data;
        if (w_ex_hit) begin
            o_data = i_ex_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Valid/ready pipeline register feeding the 32-bit ALU. Forwards
//             EX/WB results into the operands, selects immediate vs rs2,
//             supports flush and back-pressure, counts stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int OPCODE_WIDTH    = c_opcode_width,
    parameter int SA_WIDTH        = c_sa_width,
    parameter int OPERAND_WIDTH   = c_operand_width,
    parameter int REG_ADDR_WIDTH  = c_reg_addr_width,
    parameter int STALL_CNT_WIDTH = c_stall_cnt_width
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPCODE_WIDTH-1:0]    in_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rs2,
    input  logic [OPERAND_WIDTH-1:0]   in_rs1_data,
    input  logic [OPERAND_WIDTH-1:0]   in_rs2_data,
    input  logic [OPERAND_WIDTH-1:0]   in_imm,
    input  logic                       in_use_imm,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
    input  logic                       in_rd_we,
    input  logic [OPERAND_WIDTH-1:0]   alu_c,
    input  logic                       wb_we,
    input  logic [REG_ADDR_WIDTH-1:0]  wb_rd,
    input  logic [OPERAND_WIDTH-1:0]   wb_data,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [OPCODE_WIDTH-1:0]    ALUop,
    output logic [SA_WIDTH-1:0]        Sa,
    output logic [OPERAND_WIDTH-1:0]   A,
    output logic [OPERAND_WIDTH-1:0]   B,
    output logic [REG_ADDR_WIDTH-1:0]  out_rd,
    output logic                       out_rd_we,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    logic                       r_out_valid;
    logic [OPCODE_WIDTH-1:0]    r_alu_op;
    logic [SA_WIDTH-1:0]        r_sa;
    logic [OPERAND_WIDTH-1:0]   r_a;
    logic [OPERAND_WIDTH-1:0]   r_b;
    logic [REG_ADDR_WIDTH-1:0]  r_rd;
    logic                       r_rd_we;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    logic                       w_accept;
    logic                       w_ex_en;
    logic                       w_stall;
    logic [OPERAND_WIDTH-1:0]   w_fwd_rs1;
    logic [OPERAND_WIDTH-1:0]   w_fwd_rs2;
    logic [OPERAND_WIDTH-1:0]   w_b;
    logic [SA_WIDTH-1:0]        w_sa;

    // Ready does not look at flush: a flushed instruction still handshakes
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    // The held instruction is the EX producer whose result is on alu_c
    assign w_ex_en  = r_out_valid && r_rd_we;
    assign w_stall  = r_out_valid && !out_ready && !flush;

    fwd_mux #(
        .OPERAND_WIDTH  (OPERAND_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .i_rs      (in_rs1),
        .i_rf_data (in_rs1_data),
        .i_ex_en   (w_ex_en),
        .i_ex_rd   (r_rd),
        .i_ex_data (alu_c),
        .i_wb_we   (wb_we),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_data    (w_fwd_rs1)
    );

    fwd_mux #(
        .OPERAND_WIDTH  (OPERAND_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .i_rs      (in_rs2),
        .i_rf_data (in_rs2_data),
        .i_ex_en   (w_ex_en),
        .i_ex_rd   (r_rd),
        .i_ex_data (alu_c),
        .i_wb_we   (wb_we),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_data    (w_fwd_rs2)
    );

    assign w_b  = in_use_imm ? in_imm : w_fwd_rs2;
    assign w_sa = in_use_imm ? in_imm[SA_WIDTH-1:0] : w_fwd_rs2[SA_WIDTH-1:0];

    // Pipeline register: flush beats accept, accept beats drain, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_op    <= '0;
            r_sa        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_rd_we     <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu_op    <= in_alu_op;
            r_sa        <= w_sa;
            r_a         <= w_fwd_rs1;
            r_b         <= w_b;
            r_rd        <= in_rd;
            r_rd_we     <= in_rd_we;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_rd_we     <= 1'b0;
        end
    end

    // Saturating stall counter; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign ALUop     = r_alu_op;
    assign Sa        = r_sa;
    assign A         = r_a;
    assign B         = r_b;
    assign out_rd    = r_rd;
    assign out_rd_we = r_rd_we;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
